// File: rtl/fx2_fifo_responder.sv
// FX2 slave-FIFO responder: two OUT endpoints (EP2/EP4) and two IN endpoints (EP6/EP8).
// The FPGA drives the slave-FIFO strobes and a host-side byte-stream port feeds or drains the endpoints.
module fx2_fifo_responder #(
  parameter int DEPTH_LOG2 = 9,
  parameter int PKT_BYTES  = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_slcs,
  input  logic       usb_slrd,
  input  logic       usb_slwr,
  input  logic       usb_sloe,
  input  logic       usb_pktend,
  input  logic [1:0] usb_addr,
  input  logic [7:0] usb_data_in,
  output logic [7:0] usb_data_out,
  output logic       usb_ep2_empty,
  output logic       usb_ep4_empty,
  output logic       usb_ep6_full,
  output logic       usb_ep8_full,
  input  logic       host_wr_ep,
  input  logic [7:0] host_wr_data,
  input  logic       host_wr_valid,
  output logic       host_wr_ready,
  input  logic       host_rd_ep,
  output logic [7:0] host_rd_data,
  output logic       host_rd_valid,
  input  logic       host_rd_ready,
  input  logic       err_clear,
  output logic       err_overflow,
  output logic       err_underrun,
  output logic       err_protocol
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_BYTES);

  // FIFO index 0..3 maps to EP2, EP4, EP6, EP8; committed counts exist only for EP6/EP8.
  logic [7:0]            mem       [4][DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr    [4];
  logic [DEPTH_LOG2-1:0] rd_ptr    [4];
  logic [CW-1:0]         count     [4];
  logic [CW-1:0]         count_nxt [4];
  logic [CW-1:0]         ccount    [2];
  logic [CW-1:0]         ccount_nxt[2];
  logic [3:0]            push, pop, is_full, is_empty;
  logic                  cs, proto_hit, fpga_rd, fpga_wr, fpga_pkt, ovf_hit, und_hit;
  logic [1:0]            out_sel, in_sel, hwr_sel;

  assign cs      = !usb_slcs;
  assign out_sel = {1'b0, usb_addr[0]};
  assign in_sel  = {1'b1, host_rd_ep};
  assign hwr_sel = {1'b0, host_wr_ep};

  // Illegal combinations abort the whole access, including any pktend that came with it.
  assign proto_hit = cs && ((!usb_slrd && !usb_slwr) ||
                            (!usb_slrd && usb_addr[1]) ||
                            ((!usb_slwr || !usb_pktend) && !usb_addr[1]));
  assign fpga_rd   = cs && !usb_slrd && usb_slwr && !usb_addr[1] && !proto_hit;
  assign fpga_wr   = cs && !usb_slwr && usb_slrd && usb_addr[1];
  assign fpga_pkt  = cs && !usb_pktend && usb_addr[1] && !proto_hit;
  assign ovf_hit   = fpga_wr && is_full[{1'b1, usb_addr[0]}];
  assign und_hit   = fpga_rd && is_empty[out_sel];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      is_full[i]  = (count[i] == FULL_CNT);
      is_empty[i] = (count[i] == '0);
    end
    for (int i = 0; i < 2; i++) begin
      push[i]   = host_wr_valid && (host_wr_ep == 1'(i)) && !is_full[i];
      pop[i]    = fpga_rd && (usb_addr[0] == 1'(i)) && !is_empty[i];
      push[i+2] = fpga_wr && (usb_addr[0] == 1'(i)) && !is_full[i+2];
      pop[i+2]  = host_rd_ready && (host_rd_ep == 1'(i)) && (ccount[i] != '0);
    end
    for (int i = 0; i < 4; i++)
      count_nxt[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
    // A commit (explicit or auto) publishes everything written so far, including this edge's byte.
    for (int j = 0; j < 2; j++) begin
      if ((fpga_pkt && (usb_addr[0] == 1'(j))) ||
          ((count[j+2] - ccount[j] + CW'(push[j+2])) == PKT_CNT))
        ccount_nxt[j] = count_nxt[j+2];
      else
        ccount_nxt[j] = ccount[j] - CW'(pop[j+2]);
    end
  end

  // NOTE: the byte storage has no reset; pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= (i < 2) ? host_wr_data : usb_data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ccount[0]     <= '0;
      ccount[1]     <= '0;
      usb_ep2_empty <= 1'b1;
      usb_ep4_empty <= 1'b1;
      usb_ep6_full  <= 1'b0;
      usb_ep8_full  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underrun  <= 1'b0;
      err_protocol  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count_nxt[i];
      end
      ccount[0]     <= ccount_nxt[0];
      ccount[1]     <= ccount_nxt[1];
      usb_ep2_empty <= (count_nxt[0] == '0);
      usb_ep4_empty <= (count_nxt[1] == '0);
      usb_ep6_full  <= (count_nxt[2] == FULL_CNT);
      usb_ep8_full  <= (count_nxt[3] == FULL_CNT);
      err_overflow  <= (err_overflow && !err_clear) || ovf_hit;
      err_underrun  <= (err_underrun && !err_clear) || und_hit;
      err_protocol  <= (err_protocol && !err_clear) || proto_hit;
    end
  end

  assign usb_data_out  = (cs && !usb_sloe && !usb_addr[1] && !is_empty[out_sel])
                         ? mem[out_sel][rd_ptr[out_sel]] : 8'h00;
  assign host_wr_ready = !is_full[hwr_sel];
  assign host_rd_valid = (ccount[host_rd_ep] != '0);
  assign host_rd_data  = host_rd_valid ? mem[in_sel][rd_ptr[in_sel]] : 8'h00;

endmodule

// File: tb/tb_fx2_fifo_responder.sv
// Directed bench for fx2_fifo_responder: a table of single-cycle operations with
// hand-computed flags, sticky errors and read data, plus reset and packet-size sequences.
module tb_fx2_fifo_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       usb_slcs, usb_slrd, usb_slwr, usb_sloe, usb_pktend;
  logic [1:0] usb_addr;
  logic [7:0] usb_data_in, usb_data_out;
  logic       usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full;
  logic       host_wr_ep, host_wr_valid, host_wr_ready;
  logic [7:0] host_wr_data, host_rd_data;
  logic       host_rd_ep, host_rd_valid, host_rd_ready;
  logic       err_clear, err_overflow, err_underrun, err_protocol;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fx2_fifo_responder #(.DEPTH_LOG2(9), .PKT_BYTES(512)) dut (
    .clk(clk), .reset(reset),
    .usb_slcs(usb_slcs), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr),
    .usb_sloe(usb_sloe), .usb_pktend(usb_pktend), .usb_addr(usb_addr),
    .usb_data_in(usb_data_in), .usb_data_out(usb_data_out),
    .usb_ep2_empty(usb_ep2_empty), .usb_ep4_empty(usb_ep4_empty),
    .usb_ep6_full(usb_ep6_full), .usb_ep8_full(usb_ep8_full),
    .host_wr_ep(host_wr_ep), .host_wr_data(host_wr_data),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_rd_ep(host_rd_ep), .host_rd_data(host_rd_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .err_clear(err_clear), .err_overflow(err_overflow),
    .err_underrun(err_underrun), .err_protocol(err_protocol)
  );

  typedef enum logic [3:0] {
    OP_IDLE, OP_HWR, OP_FRD, OP_FWR, OP_PKT, OP_FWP, OP_HRD, OP_BAD, OP_BOTH
  } op_e;

  // flags = {ep8_full, ep6_full, ep4_empty, ep2_empty}; err = {protocol, underrun, overflow}
  typedef struct {
    op_e        op;
    logic [1:0] addr;
    logic [7:0] data;
    logic       hep;
    logic       clr;
    logic       chk_data;
    logic [7:0] exp_data;
    logic [3:0] exp_flags;
    logic [2:0] exp_err;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(op_e op, logic [1:0] addr, logic [7:0] data, logic hep,
                              logic clr, logic chk, logic [7:0] ed, logic [3:0] ef,
                              logic [2:0] ee, logic ev);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.hep = hep; v.clr = clr;
    v.chk_data = chk; v.exp_data = ed; v.exp_flags = ef; v.exp_err = ee; v.exp_valid = ev;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    usb_slcs = 1'b1; usb_slrd = 1'b1; usb_slwr = 1'b1; usb_sloe = 1'b1; usb_pktend = 1'b1;
    usb_addr = 2'b00; usb_data_in = 8'h00;
    host_wr_ep = 1'b0; host_wr_data = 8'h00; host_wr_valid = 1'b0;
    host_rd_ep = 1'b0; host_rd_ready = 1'b0; err_clear = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    idle_inputs();
    usb_addr = v.addr; host_rd_ep = v.hep; err_clear = v.clr;
    case (v.op)
      OP_HWR:  begin host_wr_ep = v.addr[0]; host_wr_data = v.data; host_wr_valid = 1'b1; end
      OP_FRD:  begin usb_slcs = 1'b0; usb_sloe = 1'b0; usb_slrd = 1'b0; end
      OP_FWR:  begin usb_slcs = 1'b0; usb_slwr = 1'b0; usb_data_in = v.data; end
      OP_PKT:  begin usb_slcs = 1'b0; usb_pktend = 1'b0; end
      OP_FWP:  begin usb_slcs = 1'b0; usb_slwr = 1'b0; usb_pktend = 1'b0; usb_data_in = v.data; end
      OP_HRD:  host_rd_ready = 1'b1;
      OP_BAD:  begin usb_slcs = 1'b0; usb_slrd = 1'b0; usb_slwr = 1'b0; end
      OP_BOTH: begin
        usb_slcs = 1'b0; usb_sloe = 1'b0; usb_slrd = 1'b0;
        host_wr_ep = 1'b0; host_wr_data = v.data; host_wr_valid = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    if (v.chk_data) begin
      if (v.op == OP_HRD) check({tag, " host_rd_data"}, 32'(host_rd_data), 32'(v.exp_data));
      else                check({tag, " usb_data_out"}, 32'(usb_data_out), 32'(v.exp_data));
    end
    @(posedge clk);
    #1;
    check({tag, " flags"}, 32'({usb_ep8_full, usb_ep6_full, usb_ep4_empty, usb_ep2_empty}),
          32'(v.exp_flags));
    check({tag, " errors"}, 32'({err_protocol, err_underrun, err_overflow}), 32'(v.exp_err));
    check({tag, " host_rd_valid"}, 32'(host_rd_valid), 32'(v.exp_valid));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    usb_slcs = 1'b0; usb_sloe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset flags", 32'({usb_ep8_full, usb_ep6_full, usb_ep4_empty, usb_ep2_empty}), 32'h3);
    check("reset errors", 32'({err_protocol, err_underrun, err_overflow}), 32'h0);
    check("reset usb_data_out", 32'(usb_data_out), 32'h00);
    check("reset host_rd_valid", 32'(host_rd_valid), 32'h0);
    check("reset host_wr_ready", 32'(host_wr_ready), 32'h1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mk(OP_HWR, 2'b00, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 4'b0010, 3'b000, 1'b0));
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mk(OP_FRD, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'(i),
                        (i == 16) ? 4'b0011 : 4'b0010, 3'b000, 1'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(OP_FWR, 2'b10, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b0));
    vecs.push_back(mk(OP_PKT, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(OP_HRD, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 4'b0011, 3'b000,
                        (i < 2) ? 1'b1 : 1'b0));
    vecs.push_back(mk(OP_FRD,  2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0011, 3'b010, 1'b0));
    vecs.push_back(mk(OP_IDLE, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b0));
    vecs.push_back(mk(OP_FRD,  2'b01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0011, 3'b010, 1'b0));
    vecs.push_back(mk(OP_IDLE, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b0));
    vecs.push_back(mk(OP_BAD,  2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0011, 3'b100, 1'b0));
    vecs.push_back(mk(OP_PKT,  2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b0));
    vecs.push_back(mk(OP_FWR,  2'b00, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0011, 3'b100, 1'b0));
    vecs.push_back(mk(OP_IDLE, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b0));
    vecs.push_back(mk(OP_FRD,  2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0011, 3'b100, 1'b0));
    vecs.push_back(mk(OP_IDLE, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b0));

    foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

    // EP8 auto-commit at 512 bytes, then overflow on the 513th write.
    for (int k = 0; k < 512; k++)
      run_vec(mk(OP_FWR, 2'b11, 8'(k), 1'b1, 1'b0, 1'b0, 8'h00,
                 (k == 511) ? 4'b1011 : 4'b0011, 3'b000, (k == 511) ? 1'b1 : 1'b0),
              $sformatf("ep8_wr%0d", k));
    run_vec(mk(OP_FWR, 2'b11, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00, 4'b1011, 3'b001, 1'b1), "ep8_ovf");
    run_vec(mk(OP_HRD, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 4'b0011, 3'b001, 1'b1), "ep8_rd0");
    run_vec(mk(OP_IDLE, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b1), "ep8_clr");

    // Mid-packet reset: 5 uncommitted EP6 bytes, 3 EP2 bytes, a pending underrun.
    for (int k = 0; k < 5; k++)
      run_vec(mk(OP_FWR, 2'b10, 8'h30 + 8'(k), 1'b0, 1'b0, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b0),
              $sformatf("pre_ep6_%0d", k));
    for (int k = 0; k < 3; k++)
      run_vec(mk(OP_HWR, 2'b00, 8'h40 + 8'(k), 1'b0, 1'b0, 1'b0, 8'h00, 4'b0010, 3'b000, 1'b0),
              $sformatf("pre_ep2_%0d", k));
    run_vec(mk(OP_FRD, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0010, 3'b010, 1'b0), "pre_und");
    @(negedge clk);
    idle_inputs();
    usb_slcs = 1'b0; usb_sloe = 1'b0; usb_addr = 2'b00;
    reset = 1'b0;
    #1;
    check("mid_rst flags", 32'({usb_ep8_full, usb_ep6_full, usb_ep4_empty, usb_ep2_empty}), 32'h3);
    check("mid_rst errors", 32'({err_protocol, err_underrun, err_overflow}), 32'h0);
    check("mid_rst usb_data_out", 32'(usb_data_out), 32'h00);
    check("mid_rst ep6 valid", 32'(host_rd_valid), 32'h0);
    host_rd_ep = 1'b1;
    #1;
    check("mid_rst ep8 valid", 32'(host_rd_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_vec(mk(OP_HWR,  2'b00, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0010, 3'b000, 1'b0), "post_hwr");
    run_vec(mk(OP_BOTH, 2'b00, 8'h66, 1'b0, 1'b0, 1'b1, 8'h55, 4'b0010, 3'b000, 1'b0), "post_both");
    run_vec(mk(OP_FRD,  2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, 4'b0011, 3'b000, 1'b0), "post_frd");
    run_vec(mk(OP_FWP,  2'b10, 8'h9C, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0011, 3'b000, 1'b1), "post_fwp");
    run_vec(mk(OP_HRD,  2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h9C, 4'b0011, 3'b000, 1'b0), "post_hrd");

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
